rom_loader: RTL and testbench



---
 rtl/rom_loader_pkg.sv | 22 ++
 rtl/rom_region_dec.sv | 48 ++++
 rtl/rom_loader.sv | 162 ++++++++++++++++
 tb/tb_rom_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and default region map for the ROM loader.
// Optional feature macro: ROM_LOADER_CKSUM_EN (adds a byte checksum output).
package rom_loader_pkg;

    // Word serialiser states: waiting for a strobe, low byte out, high byte out.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    // One-hot region select: bit0 main CPU, bit1 sound CPU, bit2 gfx, bit3 PROM.
    typedef logic [3:0] region_sel_t;

    localparam logic [7:0]  DEF_INDEX   = 8'd0;
    localparam logic [26:0] DEF_R1_BASE = 27'h0C000;
    localparam logic [26:0] DEF_R2_BASE = 27'h10000;
    localparam logic [26:0] DEF_R3_BASE = 27'h30000;
    localparam logic [26:0] DEF_R_END   = 27'h30400;
    localparam int          DEF_OFS_W   = 17;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational byte-address decoder: one-hot region select plus the
// region-relative offset. Addresses at or beyond R_END select nothing.
module rom_region_dec
    import rom_loader_pkg::*;
#(
    parameter logic [26:0] R1_BASE = DEF_R1_BASE,
    parameter logic [26:0] R2_BASE = DEF_R2_BASE,
    parameter logic [26:0] R3_BASE = DEF_R3_BASE,
    parameter logic [26:0] R_END   = DEF_R_END,
    parameter int          OFS_W   = DEF_OFS_W
) (
    input  logic [26:0]      byte_addr,
    output region_sel_t      sel,
    output logic [OFS_W-1:0] ofs
);

    // Lower bound of region i; bound(4) is the end of the last region.
    function automatic logic [26:0] bound(input int i);
        case (i)
            0:       bound = 27'd0;
            1:       bound = R1_BASE;
            2:       bound = R2_BASE;
            3:       bound = R3_BASE;
            default: bound = R_END;
        endcase
    endfunction

    logic [3:0] hit;

    // Half-open range test per region.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hit
            assign hit[gi] = (byte_addr >= bound(gi)) && (byte_addr < bound(gi + 1));
        end
    endgenerate

    // Offset from the base of whichever region matched; zero when none did.
    always_comb begin
        sel = hit;
        ofs = '0;
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
                ofs = OFS_W'(byte_addr - bound(i));
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// ROM loader: splits the 16-bit hps_io download stream into byte writes
// for the core's ROM/RAM images, throttling hps_io with ioctl_wait.
// Optional feature macro: ROM_LOADER_CKSUM_EN adds cksum[15:0], a running
// sum of every in-range byte written during the current download.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [7:0]  INDEX   = DEF_INDEX,
    parameter logic [26:0] R1_BASE = DEF_R1_BASE,
    parameter logic [26:0] R2_BASE = DEF_R2_BASE,
    parameter logic [26:0] R3_BASE = DEF_R3_BASE,
    parameter logic [26:0] R_END   = DEF_R_END,
    parameter int          OFS_W   = DEF_OFS_W
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ioctl_download,
    input  logic [7:0]       ioctl_index,
    input  logic [26:0]      ioctl_addr,
    input  logic [15:0]      ioctl_dout,
    input  logic             ioctl_wr,
    output logic             ioctl_wait,
    output region_sel_t      rom_sel,
    output logic [OFS_W-1:0] rom_addr,
    output logic [7:0]       rom_data,
    output logic             rom_we,
    output logic             loaded,
    output logic             done
`ifdef ROM_LOADER_CKSUM_EN
    ,
    output logic [15:0]      cksum
`endif
);

    state_t      state_reg;
    logic [26:0] addr_reg;
    logic [7:0]  hi_byte_reg;
    logic        active_prev_reg;
    logic        done_pend_reg;

    logic        active;
    logic        active_rise;
    logic        active_fall;
    logic [26:0] dec_addr;
    logic [7:0]  dec_data;
    region_sel_t dec_sel;
    logic [OFS_W-1:0] dec_ofs;

    assign active      = ioctl_download && (ioctl_index == INDEX);
    assign active_rise = active && !active_prev_reg;
    assign active_fall = !active && active_prev_reg;

    // The low byte is registered straight off the strobe (so it appears in
    // the first LO cycle); the high byte comes from the latched word.
    assign dec_addr = (state_reg == ST_IDLE) ? ioctl_addr : (addr_reg + 27'd1);
    assign dec_data = (state_reg == ST_IDLE) ? ioctl_dout[7:0] : hi_byte_reg;

    rom_region_dec #(
        .R1_BASE (R1_BASE),
        .R2_BASE (R2_BASE),
        .R3_BASE (R3_BASE),
        .R_END   (R_END),
        .OFS_W   (OFS_W)
    ) u_dec (
        .byte_addr (dec_addr),
        .sel       (dec_sel),
        .ofs       (dec_ofs)
    );

    // Word serialiser FSM with registered byte-write outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            hi_byte_reg <= '0;
            ioctl_wait  <= 1'b0;
            rom_we      <= 1'b0;
            rom_sel     <= '0;
            rom_addr    <= '0;
            rom_data    <= '0;
        end else begin
            rom_we   <= 1'b0;
            rom_sel  <= '0;
            rom_addr <= '0;
            rom_data <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (ioctl_wr && active) begin
                        addr_reg    <= ioctl_addr;
                        hi_byte_reg <= ioctl_dout[15:8];
                        ioctl_wait  <= 1'b1;
                        state_reg   <= ST_LO;
                        if (|dec_sel) begin
                            rom_we   <= 1'b1;
                            rom_sel  <= dec_sel;
                            rom_addr <= dec_ofs;
                            rom_data <= dec_data;
                        end
                    end
                end
                ST_LO: begin
                    state_reg <= ST_HI;
                    if (|dec_sel) begin
                        rom_we   <= 1'b1;
                        rom_sel  <= dec_sel;
                        rom_addr <= dec_ofs;
                        rom_data <= dec_data;
                    end
                end
                ST_HI: begin
                    ioctl_wait <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    ioctl_wait <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

    // Download completion: a falling edge of active is held pending until the
    // serialiser is idle, then done pulses and loaded follows a cycle later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            active_prev_reg <= 1'b0;
            done_pend_reg   <= 1'b0;
            done            <= 1'b0;
            loaded          <= 1'b0;
        end else begin
            active_prev_reg <= active;
            done            <= 1'b0;
            if (done) begin
                loaded <= 1'b1;
            end
            if ((active_fall || done_pend_reg) && (state_reg == ST_IDLE)) begin
                done          <= 1'b1;
                done_pend_reg <= 1'b0;
            end else if (active_fall) begin
                done_pend_reg <= 1'b1;
            end
            if (active_rise) begin
                loaded        <= 1'b0;
                done_pend_reg <= 1'b0;
            end
        end
    end

`ifdef ROM_LOADER_CKSUM_EN
    // Running sum of every byte actually written; restarts with each download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cksum <= '0;
        end else if (active_rise) begin
            cksum <= '0;
        end else if (rom_we) begin
            cksum <= cksum + {8'd0, rom_data};
        end
    end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected byte writes,
// a negedge monitor pops and compares every rom_we it sees.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_wait;
    logic [3:0]  rom_sel;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_we;
    logic        loaded;
    logic        done;
`ifdef ROM_LOADER_CKSUM_EN
    logic [15:0] cksum;
`endif

    rom_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .ioctl_wait     (ioctl_wait),
        .rom_sel        (rom_sel),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .loaded         (loaded),
        .done           (done)
`ifdef ROM_LOADER_CKSUM_EN
        ,
        .cksum          (cksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [3:0]  sel;
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  errors  = 0;
    int  done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: region map as a table of bounds; one expected write per in-range byte.
    task automatic ref_byte(input logic [26:0] a, input logic [7:0] d);
        int bnd[5] = '{0, 'h0C000, 'h10000, 'h30000, 'h30400};
        wr_t w;
        int  ia;
        ia = int'(a);
        for (int i = 0; i < 4; i++) begin
            if (ia >= bnd[i] && ia < bnd[i+1]) begin
                w.sel  = 4'(1 << i);
                w.addr = 17'(ia - bnd[i]);
                w.data = d;
                exp_q.push_back(w);
            end
        end
    endtask

    // One word transfer; checks the ioctl_wait envelope. drop_lo releases
    // ioctl_download during LO, dbl holds the strobe into LO (must be ignored).
    task automatic send_word(input logic [26:0] a, input logic [15:0] d,
                             input bit act, input bit drop_lo, input bit dbl);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (act) begin
            ref_byte(a, d[7:0]);
            ref_byte(a + 27'd1, d[15:8]);
        end
        @(posedge clk_sys); #1;
        if (!dbl) ioctl_wr = 1'b0;
        chk("wait_n1", {31'd0, ioctl_wait}, {31'd0, act});
        if (drop_lo) ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        chk("wait_n2", {31'd0, ioctl_wait}, {31'd0, act});
        @(posedge clk_sys); #1;
        chk("wait_n3", {31'd0, ioctl_wait}, 32'd0);
        $display("word addr=%05h dout=%04h active=%0d queued=%0d", a, d, act, exp_q.size());
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk_sys);
            n++;
        end
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 12) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("done_once", done_cnt, prev + 1);
        repeat (3) @(posedge clk_sys);
        #1;
        chk("done_still_once", done_cnt, prev + 1);
        chk("loaded_set", {31'd0, loaded}, 32'd1);
    endtask

    // Monitor: every rom_we must match the head of the queue; idle cycles
    // must present zero select and offset.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (done) done_cnt++;
            if (rom_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", {11'd0, rom_sel, rom_addr}, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_sel",  {28'd0, rom_sel},  {28'd0, w.sel});
                    chk("wr_addr", {15'd0, rom_addr}, {15'd0, w.addr});
                    chk("wr_data", {24'd0, rom_data}, {24'd0, w.data});
                    $display("write sel=%b addr=%05h data=%02h", rom_sel, rom_addr, rom_data);
                end
            end else begin
                chk("idle_sel",  {28'd0, rom_sel},  32'd0);
                chk("idle_addr", {15'd0, rom_addr}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        logic [26:0] a;
        int bnd_pick[5] = '{'h0C000, 'h10000, 'h30000, 'h30400, 'h00000};

        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_wait",   {31'd0, ioctl_wait}, 32'd0);
        chk("rst_we",     {31'd0, rom_we},     32'd0);
        chk("rst_sel",    {28'd0, rom_sel},    32'd0);
        chk("rst_addr",   {15'd0, rom_addr},   32'd0);
        chk("rst_data",   {24'd0, rom_data},   32'd0);
        chk("rst_loaded", {31'd0, loaded},     32'd0);
        chk("rst_done",   {31'd0, done},       32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Directed words on the main download
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        send_word(27'h00000, 16'hA55A, 1'b1, 1'b0, 1'b0);
        send_word(27'h0BFFE, 16'h1234, 1'b1, 1'b0, 1'b0);
        send_word(27'h0C000, 16'h5678, 1'b1, 1'b0, 1'b0);
        send_word(27'h0FFFE, 16'h9ABC, 1'b1, 1'b0, 1'b0);
        send_word(27'h2FFFE, 16'hDEF0, 1'b1, 1'b0, 1'b0);
        send_word(27'h303FE, 16'h0F1E, 1'b1, 1'b0, 1'b0);
        send_word(27'h30400, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send_word(27'h00010, 16'h4321, 1'b1, 1'b0, 1'b1);

        // Randomized words, half of them clustered around region bounds
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 27'($urandom_range(0, 'h183FF)) << 1;
            end else begin
                a = 27'(bnd_pick[$urandom_range(0, 4)]) + 27'($urandom_range(0, 7) << 1) - 27'd8;
                if (a > 27'h30800) a = 27'd0;
            end
            send_word(a, 16'($urandom), 1'b1, 1'b0, 1'b0);
        end
        drain();

        // End of download while idle
        prev = done_cnt;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        wait_done(prev);

        // Other index: ignored entirely, loaded untouched
        prev = done_cnt;
        @(negedge clk_sys);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        send_word(27'h00000, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("idx1_loaded", {31'd0, loaded}, 32'd1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        chk("idx1_no_done", done_cnt, prev);
        chk("idx1_loaded2", {31'd0, loaded}, 32'd1);

        // Four-word download ending while the last word is in LO
        @(negedge clk_sys);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rise_clears_loaded", {31'd0, loaded}, 32'd0);
        prev = done_cnt;
        for (int i = 0; i < 3; i++) begin
            send_word(27'h10000 + 27'(i * 2), 16'($urandom), 1'b1, 1'b0, 1'b0);
        end
        send_word(27'h10006, 16'h7788, 1'b1, 1'b1, 1'b0);
        wait_done(prev);
        drain();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rerise_clears_loaded", {31'd0, loaded}, 32'd0);

        // Reset asserted during LO
        @(negedge clk_sys);
        ioctl_addr = 27'h00100;
        ioctl_dout = 16'h1234;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("rst_lo_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rst_lo_we",   {31'd0, rom_we},     32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        send_word(27'h00000, 16'hFF01, 1'b1, 1'b0, 1'b0);
        send_word(27'h00002, 16'h0010, 1'b1, 1'b0, 1'b0);
        drain();
`ifdef ROM_LOADER_CKSUM_EN
        chk("cksum", {16'd0, cksum}, 32'h0110);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
